cache_set_assoc: RTL and testbench

Parametrised N-way set-associative read cache between a requester and a slower backing memory. It looks up each requested address, returns hits with a registered one-cycle latency, and on a miss issues a single-address fetch to memory. The fetch tolerates a variable response latency, and the cache fills a victim way chosen per set. It is the generalised successor of the directly mapped cache: configurable ways, explicit fill handshake, flush, and selectable replacement.

---
 rtl/cache_set_assoc.sv | 168 ++++++++++++++++
 tb/tb_cache_set_assoc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_set_assoc.sv
// N-way set-associative read cache with a miss-fetch handshake, flush, and per-set replacement.
// Define CACHE_PLRU_EN for tree pseudo-LRU; the default build uses a per-set round-robin pointer.
module cache_set_assoc #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int SET_BITS   = 4,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  addr_in_valid,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  addr_in_ready,
  output logic                  data_out_valid,
  output logic [DWIDTH-1:0]     data_out,
  output logic                  addr_out_valid,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic                  addr_out_ready,
  input  logic                  data_in_valid,
  input  logic [DWIDTH-1:0]     data_in
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_WIDTH - SET_BITS;
  localparam int LVL   = $clog2(WAYS);
  localparam int WAY_W = (WAYS > 1) ? LVL : 1;
`ifdef CACHE_PLRU_EN
  localparam int REP_W = (WAYS > 1) ? WAYS - 1 : 1;
`else
  localparam int REP_W = WAY_W;
`endif

  typedef enum logic [1:0] {S_LOOKUP, S_REQ, S_WAIT} state_t;
  state_t state;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DWIDTH-1:0] data_q  [SETS][WAYS];
  logic [REP_W-1:0]  rep_q   [SETS];

  logic [SET_BITS-1:0] lk_set, f_set;
  logic [TAG_W-1:0]    lk_tag, f_tag;
  logic                hit, found, accept, fill;
  logic [WAY_W-1:0]    hit_way, victim;
  logic [DWIDTH-1:0]   hit_data;
  logic [REP_W-1:0]    rep_fill, rep_hit;

  // addr_out doubles as the latched miss address for the fill.
  assign lk_set = addr_in[SET_BITS-1:0];
  assign lk_tag = addr_in[ADDR_WIDTH-1:SET_BITS];
  assign f_set  = addr_out[SET_BITS-1:0];
  assign f_tag  = addr_out[ADDR_WIDTH-1:SET_BITS];

`ifdef CACHE_PLRU_EN
  // Heap-ordered tree: node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [REP_W-1:0] b);
    int  n;
    logic bit_n;
    n = 0;
    for (int l = 0; l < LVL; l++) begin
      bit_n = 1'b0;
      for (int j = 0; j < REP_W; j++) if (j == n) bit_n = b[j];
      n = 2 * n + (bit_n ? 2 : 1);
    end
    return WAY_W'(n - (WAYS - 1));
  endfunction

  function automatic logic [REP_W-1:0] plru_touch(input logic [REP_W-1:0] b,
                                                  input logic [WAY_W-1:0] w);
    logic [REP_W-1:0] r;
    int  n;
    logic d;
    r = b;
    n = 0;
    for (int l = 0; l < LVL; l++) begin
      d = w[LVL-1-l];
      for (int j = 0; j < REP_W; j++) if (j == n) r[j] = ~d;
      n = 2 * n + (d ? 2 : 1);
    end
    return r;
  endfunction

  assign rep_fill = plru_touch(rep_q[f_set], victim);
  assign rep_hit  = plru_touch(rep_q[lk_set], hit_way);
`else
  assign rep_fill = (WAYS > 1) ? rep_q[f_set] + 1'b1 : '0;
  assign rep_hit  = rep_q[lk_set];
`endif

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    hit_data = data_q[lk_set][hit_way];
  end

  always_comb begin
    found = 1'b0;
`ifdef CACHE_PLRU_EN
    victim = plru_victim(rep_q[f_set]);
`else
    victim = rep_q[f_set];
`endif
    for (int w = 0; w < WAYS; w++)
      if (!found && !valid_q[f_set][w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
  end

  assign accept        = (state == S_LOOKUP) && addr_in_valid && hit && !flush;
  assign fill          = (state == S_WAIT) && data_in_valid;
  assign addr_in_ready = accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_LOOKUP;
      addr_out_valid <= 1'b0;
      addr_out       <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rep_q[s]   <= '0;
      end
    end else begin
      data_out_valid <= accept;
      if (accept) data_out <= hit_data;
      case (state)
        S_LOOKUP: if (addr_in_valid && !hit) begin
          state          <= S_REQ;
          addr_out_valid <= 1'b1;
          addr_out       <= addr_in;
        end
        S_REQ: if (addr_out_ready) begin
          state          <= S_WAIT;
          addr_out_valid <= 1'b0;
        end
        S_WAIT: if (data_in_valid) state <= S_LOOKUP;
        default: state <= S_LOOKUP;
      endcase
      // A fill landing with flush stays invalid because the flush branch wins.
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rep_q[s]   <= '0;
        end
      end else begin
        if (fill) begin
          valid_q[f_set][victim] <= 1'b1;
          rep_q[f_set]           <= rep_fill;
        end
        if (accept) rep_q[lk_set] <= rep_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !reset) begin
      tag_q[f_set][victim]  <= f_tag;
      data_q[f_set][victim] <= data_in;
    end
  end
endmodule

// File: tb/tb_cache_set_assoc.sv
// Scoreboard bench for cache_set_assoc: a driver issues reads and plays memory, a monitor checks data_out.
// The reference keeps full addresses per set/way; compile with CACHE_PLRU_EN to match the PLRU build.
module tb_cache_set_assoc;
  localparam int DW = 16, AW = 16, SB = 4, WAYS = 2, SETS = 16;

  logic clk = 1'b0;
  logic reset, flush, addr_in_valid, addr_in_ready, data_out_valid;
  logic addr_out_valid, addr_out_ready, data_in_valid;
  logic [AW-1:0] addr_in, addr_out;
  logic [DW-1:0] data_out, data_in;

  always #5 clk = ~clk;

  cache_set_assoc #(.DWIDTH(DW), .ADDR_WIDTH(AW), .SET_BITS(SB), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .addr_in_valid(addr_in_valid), .addr_in(addr_in), .addr_in_ready(addr_in_ready),
    .data_out_valid(data_out_valid), .data_out(data_out),
    .addr_out_valid(addr_out_valid), .addr_out(addr_out), .addr_out_ready(addr_out_ready),
    .data_in_valid(data_in_valid), .data_in(data_in));

  int tests = 0, fails = 0;
  logic [DW-1:0] exp_q[$];

  // Reference: which addresses live in each set, plus the eviction choice.
  bit            m_valid [SETS][WAYS];
  logic [AW-1:0] m_addr  [SETS][WAYS];
  logic [DW-1:0] m_data  [SETS][WAYS];
  int            m_ptr   [SETS];
  int            m_lru   [SETS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      m_ptr[s] = 0;
      m_lru[s] = 0;
    end
  endfunction

  function automatic int m_find(input logic [AW-1:0] a);
    int s = int'(a[SB-1:0]);
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_addr[s][w] == a) return w;
    return -1;
  endfunction

  // With two ways, pseudo-LRU is exact LRU: evict the way not used most recently.
  function automatic void m_fill(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int s = int'(a[SB-1:0]);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
`ifdef CACHE_PLRU_EN
    if (v < 0) v = m_lru[s];
`else
    if (v < 0) v = m_ptr[s];
`endif
    m_valid[s][v] = 1'b1;
    m_addr[s][v]  = a;
    m_data[s][v]  = d;
    m_ptr[s]      = (m_ptr[s] + 1) % WAYS;
    m_lru[s]      = (v + 1) % WAYS;
  endfunction

  always @(negedge clk) begin
    if (!reset && data_out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_data_out_valid", 32'(data_out_valid), 32'd0);
      else chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  // Issue one read; on a miss act as memory (stall cycles in S_REQ, wt cycles before data).
  task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall,
                      input int wt, input bit fl_fill, output bit missed);
    int  w, s;
    bit  fl, done;
    fl = fl_fill; done = 1'b0; missed = 1'b0;
    s = int'(a[SB-1:0]);
    for (int tries = 0; tries < 4 && !done; tries++) begin
      w = m_find(a);
      addr_in_valid = 1'b1; addr_in = a;
      @(negedge clk);
      if (tries == 0) missed = !addr_in_ready;
      chk("lookup_hit", 32'(addr_in_ready), 32'(w >= 0));
      chk("no_fetch_in_lookup", 32'(addr_out_valid), 32'd0);
      if (w >= 0) begin
        exp_q.push_back(m_data[s][w]);
        m_lru[s] = (w + 1) % WAYS;
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          chk("req_valid_held", 32'(addr_out_valid), 32'd1);
          chk("req_addr_stable", 32'(addr_out), 32'(a));
          chk("req_ready_low", 32'(addr_in_ready), 32'd0);
          @(posedge clk); #1;
        end
        addr_out_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", 32'(addr_out_valid), 32'd1);
        chk("req_addr", 32'(addr_out), 32'(a));
        @(posedge clk); #1;
        addr_out_ready = 1'b0;
        for (int k = 0; k < wt; k++) begin
          @(negedge clk);
          chk("wait_no_fetch", 32'(addr_out_valid), 32'd0);
          chk("wait_ready_low", 32'(addr_in_ready), 32'd0);
          @(posedge clk); #1;
        end
        data_in_valid = 1'b1; data_in = d; flush = fl;
        @(posedge clk); #1;
        data_in_valid = 1'b0; flush = 1'b0;
        if (fl) m_clear(); else m_fill(a, d);
        fl = 1'b0;
      end
    end
    addr_in_valid = 1'b0;
    chk("replay_completed", 32'(done), 32'd1);
  endtask

  task automatic flush_pulse(input logic [AW-1:0] a);
    addr_in_valid = (m_find(a) >= 0);
    addr_in = a; flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", 32'(addr_in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; addr_in_valid = 1'b0;
    m_clear();
    @(negedge clk);
    chk("idle_ready_low", 32'(addr_in_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_in_wait(input logic [AW-1:0] a);
    addr_in_valid = 1'b1; addr_in = a;
    @(posedge clk); #1;
    addr_out_ready = 1'b1;
    @(posedge clk); #1;
    addr_out_ready = 1'b0; addr_in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; data_in_valid = 1'b1; data_in = 16'h7777;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    m_clear();
    @(negedge clk);
    chk("rst_addr_out_valid", 32'(addr_out_valid), 32'd0);
    chk("rst_addr_out", 32'(addr_out), 32'd0);
    chk("rst_data_out_valid", 32'(data_out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ready", 32'(addr_in_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit missed;
    logic [AW-1:0] a;
    reset = 1'b1; flush = 1'b0; addr_in_valid = 1'b0; addr_in = '0;
    addr_out_ready = 1'b0; data_in_valid = 1'b0; data_in = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_data_out_valid", 32'(data_out_valid), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_addr_out_valid", 32'(addr_out_valid), 32'd0);
    chk("reset_addr_out", 32'(addr_out), 32'd0);
    chk("reset_ready", 32'(addr_in_ready), 32'd0);
    @(posedge clk); #1;

    read(16'h0012, 16'hBEEF, 0, 3, 1'b0, missed);
    chk("first_read_misses", 32'(missed), 32'd1);

    read(16'h0013, 16'h1111, 0, 0, 1'b0, missed);
    read(16'h1013, 16'h2222, 1, 1, 1'b0, missed);
    read(16'h0013, 16'h0, 0, 0, 1'b0, missed);
    chk("two_way_hit_0013", 32'(missed), 32'd0);
    read(16'h1013, 16'h0, 0, 0, 1'b0, missed);
    chk("two_way_hit_1013", 32'(missed), 32'd0);
    read(16'h0013, 16'h0, 0, 0, 1'b0, missed);
    read(16'h2013, 16'h3333, 0, 0, 1'b0, missed);
    chk("conflict_misses", 32'(missed), 32'd1);
`ifdef CACHE_PLRU_EN
    read(16'h0013, 16'h0, 0, 0, 1'b0, missed);
    chk("plru_keeps_0013", 32'(missed), 32'd0);
    read(16'h1013, 16'h4444, 0, 0, 1'b0, missed);
    chk("plru_evicted_1013", 32'(missed), 32'd1);
`else
    read(16'h1013, 16'h0, 0, 0, 1'b0, missed);
    chk("rr_keeps_1013", 32'(missed), 32'd0);
    read(16'h0013, 16'h4444, 0, 0, 1'b0, missed);
    chk("rr_evicted_0013", 32'(missed), 32'd1);
`endif

    read(16'h0444, 16'h5A5A, 5, 2, 1'b0, missed);

    flush_pulse(16'h0012);
    read(16'h0012, 16'hBEEF, 0, 1, 1'b0, missed);
    chk("miss_after_flush", 32'(missed), 32'd1);
    read(16'h0055, 16'h6666, 0, 1, 1'b1, missed);
    chk("flush_fill_miss", 32'(missed), 32'd1);

    reset_in_wait(16'h0077);
    read(16'h0077, 16'h8888, 0, 0, 1'b0, missed);
    chk("miss_after_reset", 32'(missed), 32'd1);

    for (int i = 0; i < 200; i++) begin
      a = AW'($urandom_range(0, 3) * 32'h1000 + $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) flush_pulse(a);
      else read(a, DW'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0), missed);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
